fsm_trace_monitor: RTL and testbench

- Downstream observer of the five-state switch-driven controller.
- Samples the controller's State[2:0] and Z[1:0] outputs on the same KEY0 edge that advances the controller.
- Counts state visits and transitions, flags illegal transitions and State/Z mismatches, and keeps a short state history for board-level debug (LEDs / 7-seg).
- Purely passive: never drives the controller.

---
 rtl/fsm_trace_monitor.sv | 147 ++++++++++++++
 tb/tb_fsm_trace_monitor.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fsm_trace_monitor.sv
// rtl/fsm_trace_monitor.sv - passive observer of the five-state controller: visits, transitions, illegal/Z checks
// Optional state history shift register enabled by FSM_MON_HISTORY_EN.
module fsm_trace_monitor #(
  parameter int CW     = 8,
  parameter int HIST_D = 4
) (
  input  logic                KEY0,
  input  logic                KEY1,
  input  logic [2:0]          State,
  input  logic [1:0]          Z,
  input  logic [2:0]          sel,
  output logic [CW-1:0]       visit_cnt,
  output logic [CW-1:0]       trans_cnt,
  output logic                started,
  output logic                illegal_flag,
  output logic [2:0]          illegal_from,
  output logic [2:0]          illegal_to,
  output logic                z_err_flag,
  output logic [3*HIST_D-1:0] history
);

  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  logic [CW-1:0] visit_q [5];
  logic [CW-1:0] visit_d [5];
  logic [CW-1:0] trans_q, trans_d;
  logic          started_q, started_d;
  logic [2:0]    prev_q, prev_d;
  logic          illegal_q, illegal_d;
  logic [2:0]    from_q, from_d;
  logic [2:0]    to_q, to_d;
  logic          zerr_q, zerr_d;

  logic valid_state;
  logic state_changed;
  logic illegal_evt;
  logic z_bad;

  function automatic logic trans_ok(input logic [2:0] f, input logic [2:0] t);
    if (t == f || t == 3'd0) return 1'b1;
    case ({f, t})
      6'o01, 6'o03, 6'o12, 6'o21, 6'o23, 6'o31, 6'o34, 6'o41: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] z_req(input logic [2:0] s);
    case (s)
      3'd0:    return 2'b01;
      3'd1:    return 2'b10;
      3'd4:    return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  always_comb begin
    valid_state   = (State <= 3'd4);
    // The very first sample has no predecessor, so it never counts as a change.
    state_changed = started_q && (State != prev_q);
    illegal_evt   = !valid_state || (started_q && !trans_ok(prev_q, State));
    z_bad         = !valid_state || (Z != z_req(State));

    for (int i = 0; i < 5; i++) visit_d[i] = visit_q[i];
    trans_d   = trans_q;
    started_d = 1'b1;
    prev_d    = State;
    illegal_d = illegal_q;
    from_d    = from_q;
    to_d      = to_q;
    zerr_d    = zerr_q | z_bad;

    if (state_changed && trans_q != CNT_MAX) trans_d = trans_q + CNT_ONE;

    if (valid_state && (!started_q || state_changed)) begin
      for (int i = 0; i < 5; i++) begin
        if (State == 3'(i) && visit_q[i] != CNT_MAX) visit_d[i] = visit_q[i] + CNT_ONE;
      end
    end

    if (illegal_evt) begin
      illegal_d = 1'b1;
      if (!illegal_q) begin
        from_d = prev_q;
        to_d   = State;
      end
    end
  end

  always_ff @(posedge KEY0 or negedge KEY1) begin
    if (!KEY1) begin
      for (int i = 0; i < 5; i++) visit_q[i] <= '0;
      trans_q   <= '0;
      started_q <= 1'b0;
      prev_q    <= 3'd0;
      illegal_q <= 1'b0;
      from_q    <= 3'd0;
      to_q      <= 3'd0;
      zerr_q    <= 1'b0;
    end else begin
      for (int i = 0; i < 5; i++) visit_q[i] <= visit_d[i];
      trans_q   <= trans_d;
      started_q <= started_d;
      prev_q    <= prev_d;
      illegal_q <= illegal_d;
      from_q    <= from_d;
      to_q      <= to_d;
      zerr_q    <= zerr_d;
    end
  end

  always_comb begin
    case (sel)
      3'd0:    visit_cnt = visit_q[0];
      3'd1:    visit_cnt = visit_q[1];
      3'd2:    visit_cnt = visit_q[2];
      3'd3:    visit_cnt = visit_q[3];
      3'd4:    visit_cnt = visit_q[4];
      default: visit_cnt = '0;
    endcase
  end

  assign trans_cnt    = trans_q;
  assign started      = started_q;
  assign illegal_flag = illegal_q;
  assign illegal_from = from_q;
  assign illegal_to   = to_q;
  assign z_err_flag   = zerr_q;

`ifdef FSM_MON_HISTORY_EN
  logic [3*HIST_D-1:0] hist_q, hist_d;

  always_comb begin
    hist_d = {hist_q[3*HIST_D-4:0], State};
  end

  always_ff @(posedge KEY0 or negedge KEY1) begin
    if (!KEY1) hist_q <= '0;
    else       hist_q <= hist_d;
  end

  assign history = hist_q;
`else
  assign history = '0;
`endif

endmodule

// File: tb/tb_fsm_trace_monitor.sv
// tb/tb_fsm_trace_monitor.sv - directed self-checking bench for fsm_trace_monitor
// Checks history contents when FSM_MON_HISTORY_EN is defined, constant zero otherwise.
module tb_fsm_trace_monitor;

  logic       KEY0 = 1'b0;
  logic       KEY1 = 1'b0;
  logic [2:0] State = 3'd0;
  logic [1:0] Z = 2'b01;
  logic [2:0] sel = 3'd0;
  logic [7:0] visit_cnt, trans_cnt;
  logic       started, illegal_flag, z_err_flag;
  logic [2:0] illegal_from, illegal_to;
  logic [11:0] history;

  logic [2:0] st2 = 3'd0;
  logic [1:0] z2 = 2'b01;
  logic [2:0] sel2 = 3'd0;
  logic [1:0] visit_cnt2, trans_cnt2;
  logic       started2, illegal_flag2, z_err_flag2;
  logic [2:0] illegal_from2, illegal_to2;
  logic [11:0] history2;

  int checks = 0;
  int errors = 0;

  fsm_trace_monitor #(.CW(8), .HIST_D(4)) dut (
    .KEY0(KEY0), .KEY1(KEY1), .State(State), .Z(Z), .sel(sel),
    .visit_cnt(visit_cnt), .trans_cnt(trans_cnt), .started(started),
    .illegal_flag(illegal_flag), .illegal_from(illegal_from), .illegal_to(illegal_to),
    .z_err_flag(z_err_flag), .history(history)
  );

  fsm_trace_monitor #(.CW(2), .HIST_D(4)) dut_sat (
    .KEY0(KEY0), .KEY1(KEY1), .State(st2), .Z(z2), .sel(sel2),
    .visit_cnt(visit_cnt2), .trans_cnt(trans_cnt2), .started(started2),
    .illegal_flag(illegal_flag2), .illegal_from(illegal_from2), .illegal_to(illegal_to2),
    .z_err_flag(z_err_flag2), .history(history2)
  );

  initial forever #5 KEY0 = ~KEY0;

  task automatic drive(input logic [2:0] s, input logic [1:0] z);
    State = s;
    Z = z;
    @(posedge KEY0);
    #1;
  endtask

  task automatic pulse_reset();
    KEY1 = 1'b0;
    #2;
    KEY1 = 1'b1;
  endtask

  task automatic test_reset();
    KEY1 = 1'b0;
    #3;
    checks++; if (started !== 1'b0) begin errors++; $display("FAIL reset_started got=%0d exp=0", started); end
    checks++; if (trans_cnt !== 8'd0) begin errors++; $display("FAIL reset_trans got=%0d exp=0", trans_cnt); end
    checks++; if (illegal_flag !== 1'b0 || z_err_flag !== 1'b0) begin errors++; $display("FAIL reset_flags got=%0d/%0d exp=0/0", illegal_flag, z_err_flag); end
    checks++; if (illegal_from !== 3'd0 || illegal_to !== 3'd0) begin errors++; $display("FAIL reset_from_to got=%0d/%0d exp=0/0", illegal_from, illegal_to); end
    checks++; if (history !== 12'd0) begin errors++; $display("FAIL reset_history got=%h exp=000", history); end
    for (int i = 0; i < 5; i++) begin
      sel = 3'(i);
      #1;
      checks++; if (visit_cnt !== 8'd0) begin errors++; $display("FAIL reset_visit[%0d] got=%0d exp=0", i, visit_cnt); end
    end
    @(posedge KEY0);
    #1;
    KEY1 = 1'b1;
  endtask

  task automatic test_hold();
    repeat (3) drive(3'd0, 2'b01);
    sel = 3'd0;
    #1;
    checks++; if (started !== 1'b1) begin errors++; $display("FAIL hold_started got=%0d exp=1", started); end
    checks++; if (visit_cnt !== 8'd1) begin errors++; $display("FAIL hold_visit0 got=%0d exp=1", visit_cnt); end
    checks++; if (trans_cnt !== 8'd0) begin errors++; $display("FAIL hold_trans got=%0d exp=0", trans_cnt); end
    checks++; if (illegal_flag !== 1'b0 || z_err_flag !== 1'b0) begin errors++; $display("FAIL hold_flags got=%0d/%0d exp=0/0", illegal_flag, z_err_flag); end
  endtask

  task automatic test_sequence();
    logic [7:0] exp_v [5];
    exp_v = '{8'd2, 8'd1, 8'd1, 8'd1, 8'd1};
    drive(3'd1, 2'b10);
    drive(3'd2, 2'b00);
    drive(3'd3, 2'b00);
    drive(3'd4, 2'b11);
    drive(3'd0, 2'b01);
    checks++; if (trans_cnt !== 8'd5) begin errors++; $display("FAIL seq_trans got=%0d exp=5", trans_cnt); end
    checks++; if (illegal_flag !== 1'b0 || z_err_flag !== 1'b0) begin errors++; $display("FAIL seq_flags got=%0d/%0d exp=0/0", illegal_flag, z_err_flag); end
`ifdef FSM_MON_HISTORY_EN
    checks++; if (history !== 12'b010_011_100_000) begin errors++; $display("FAIL seq_history got=%b exp=010011100000", history); end
`else
    checks++; if (history !== 12'd0) begin errors++; $display("FAIL seq_history got=%b exp=0", history); end
`endif
    for (int i = 0; i < 6; i++) begin
      sel = 3'(i);
      #1;
      checks++;
      if (visit_cnt !== ((i < 5) ? exp_v[i] : 8'd0)) begin
        errors++;
        $display("FAIL seq_visit[%0d] got=%0d exp=%0d", i, visit_cnt, (i < 5) ? exp_v[i] : 8'd0);
      end
    end
  endtask

  task automatic test_illegal();
    pulse_reset();
    drive(3'd0, 2'b01);
    drive(3'd2, 2'b00);
    checks++; if (illegal_flag !== 1'b1) begin errors++; $display("FAIL ill_flag_first got=%0d exp=1", illegal_flag); end
    checks++; if (illegal_from !== 3'd0 || illegal_to !== 3'd2) begin errors++; $display("FAIL ill_first_event got=%0d->%0d exp=0->2", illegal_from, illegal_to); end
    drive(3'd1, 2'b10);
    drive(3'd3, 2'b00);
    checks++; if (illegal_flag !== 1'b1) begin errors++; $display("FAIL ill_flag_sticky got=%0d exp=1", illegal_flag); end
    checks++; if (illegal_from !== 3'd0 || illegal_to !== 3'd2) begin errors++; $display("FAIL ill_kept_event got=%0d->%0d exp=0->2", illegal_from, illegal_to); end
    checks++; if (z_err_flag !== 1'b0) begin errors++; $display("FAIL ill_zerr got=%0d exp=0", z_err_flag); end
  endtask

  task automatic test_zerr();
    pulse_reset();
    drive(3'd4, 2'b00);
    checks++; if (z_err_flag !== 1'b1) begin errors++; $display("FAIL z_flag got=%0d exp=1", z_err_flag); end
    checks++; if (illegal_flag !== 1'b0) begin errors++; $display("FAIL z_illegal got=%0d exp=0", illegal_flag); end
    drive(3'd6, 2'b00);
    checks++; if (illegal_flag !== 1'b1 || z_err_flag !== 1'b1) begin errors++; $display("FAIL inv_flags got=%0d/%0d exp=1/1", illegal_flag, z_err_flag); end
    checks++; if (illegal_from !== 3'd4 || illegal_to !== 3'd6) begin errors++; $display("FAIL inv_event got=%0d->%0d exp=4->6", illegal_from, illegal_to); end
    for (int i = 0; i < 8; i++) begin
      sel = 3'(i);
      #1;
      checks++;
      if (visit_cnt !== ((i == 4) ? 8'd1 : 8'd0)) begin
        errors++;
        $display("FAIL inv_visit[%0d] got=%0d exp=%0d", i, visit_cnt, (i == 4) ? 1 : 0);
      end
    end
  endtask

  task automatic test_saturate();
    pulse_reset();
    for (int i = 0; i < 6; i++) begin
      st2 = (i % 2 == 0) ? 3'd0 : 3'd1;
      z2  = (i % 2 == 0) ? 2'b01 : 2'b10;
      @(posedge KEY0);
      #1;
    end
    checks++; if (trans_cnt2 !== 2'd3) begin errors++; $display("FAIL sat_trans got=%0d exp=3", trans_cnt2); end
    sel2 = 3'd0;
    #1;
    checks++; if (visit_cnt2 !== 2'd3) begin errors++; $display("FAIL sat_visit0 got=%0d exp=3", visit_cnt2); end
    sel2 = 3'd1;
    #1;
    checks++; if (visit_cnt2 !== 2'd3) begin errors++; $display("FAIL sat_visit1 got=%0d exp=3", visit_cnt2); end
    checks++; if (illegal_flag2 !== 1'b0 || z_err_flag2 !== 1'b0) begin errors++; $display("FAIL sat_flags got=%0d/%0d exp=0/0", illegal_flag2, z_err_flag2); end
  endtask

  task automatic test_mid_reset();
    pulse_reset();
    drive(3'd0, 2'b01);
    drive(3'd1, 2'b10);
    drive(3'd2, 2'b00);
    drive(3'd3, 2'b00);
    drive(3'd4, 2'b11);
    drive(3'd0, 2'b10);
    KEY1 = 1'b0;
    #1;
    checks++; if (started !== 1'b0 || trans_cnt !== 8'd0) begin errors++; $display("FAIL mid_counts got=%0d/%0d exp=0/0", started, trans_cnt); end
    checks++; if (z_err_flag !== 1'b0 || illegal_flag !== 1'b0) begin errors++; $display("FAIL mid_flags got=%0d/%0d exp=0/0", z_err_flag, illegal_flag); end
    checks++; if (history !== 12'd0) begin errors++; $display("FAIL mid_history got=%h exp=000", history); end
    sel = 3'd1;
    #1;
    checks++; if (visit_cnt !== 8'd0) begin errors++; $display("FAIL mid_visit1 got=%0d exp=0", visit_cnt); end
    KEY1 = 1'b1;
    drive(3'd3, 2'b00);
    sel = 3'd3;
    #1;
    checks++; if (visit_cnt !== 8'd1) begin errors++; $display("FAIL post_visit3 got=%0d exp=1", visit_cnt); end
    checks++; if (trans_cnt !== 8'd0 || started !== 1'b1) begin errors++; $display("FAIL post_trans_started got=%0d/%0d exp=0/1", trans_cnt, started); end
    checks++; if (illegal_flag !== 1'b0) begin errors++; $display("FAIL post_illegal got=%0d exp=0", illegal_flag); end
  endtask

  initial begin
    test_reset();
    test_hold();
    test_sequence();
    test_illegal();
    test_zerr();
    test_saturate();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
